// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Purpose:
//   MEM pipeline stage sitting directly after EX. Non-memory instructions
//   pass through to WB in one cycle. LDB/LDW/STB/STW are issued to the data
//   memory over a req/ack handshake with variable latency; while an access
//   is outstanding the stage holds the front-end via O_MEMStallSignal.
//   An access that sees no ack for TIMEOUT_CYCLES cycles is abandoned.
//   All state updates happen on the falling edge of I_CLOCK.
//
// Configuration macro:
//   MEM_ALIGN_CHECK_EN - when defined, LDW/STW with addr[0]=1 are never
//                        issued; O_MemError pulses and the instruction
//                        retires as a bubble. When undefined, addr[0] is
//                        silently cleared for word accesses.
//
// Ports:
//   I_CLOCK, I_RESET_N     clock (negedge active), async active-low reset
//   I_LOCK                 pipeline run/lock
//   I_EX_Valid .. I_MDRValue
//                          registered EX outputs (opcode, PC, IR, dest,
//                          ALU value, write enables, CC, MAR, MDR)
//   O_DMemReq/WE/Addr/WData/ByteEn, I_DMemAck, I_DMemRData
//                          data-memory handshake (word address, lane enables)
//   O_LOCK .. O_CCValue    registered WB-stage inputs
//   O_MEMStallSignal       combinational, high while an access is pending
//   O_MemError             one-cycle pulse on timeout or misaligned access
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          DATA_WIDTH     = 16,
  parameter int          TIMEOUT_CYCLES = 64,
  // Opcode values shared with the rest of the pipeline's decoder.
  parameter logic [7:0]  OP_LDB         = 8'h02,
  parameter logic [7:0]  OP_STB         = 8'h03,
  parameter logic [7:0]  OP_LDW         = 8'h06,
  parameter logic [7:0]  OP_STW         = 8'h07
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET_N,
  input  logic                  I_LOCK,
  input  logic                  I_EX_Valid,
  input  logic [7:0]            I_Opcode,
  input  logic [15:0]           I_PC,
  input  logic [31:0]           I_IR,
  input  logic [3:0]            I_DestRegIdx,
  input  logic [DATA_WIDTH-1:0] I_DestValue,
  input  logic                  I_RegWEn,
  input  logic                  I_CCWEn,
  input  logic [2:0]            I_CCValue,
  input  logic [ADDR_WIDTH-1:0] I_MARValue,
  input  logic [DATA_WIDTH-1:0] I_MDRValue,
  output logic                  O_DMemReq,
  output logic                  O_DMemWE,
  output logic [ADDR_WIDTH-1:0] O_DMemAddr,
  output logic [DATA_WIDTH-1:0] O_DMemWData,
  output logic [1:0]            O_DMemByteEn,
  input  logic                  I_DMemAck,
  input  logic [DATA_WIDTH-1:0] I_DMemRData,
  output logic                  O_LOCK,
  output logic                  O_MEM_Valid,
  output logic [15:0]           O_PC,
  output logic [31:0]           O_IR,
  output logic [3:0]            O_DestRegIdx,
  output logic [DATA_WIDTH-1:0] O_DestValue,
  output logic                  O_RegWEn,
  output logic                  O_CCWEn,
  output logic [2:0]            O_CCValue,
  output logic                  O_MEMStallSignal,
  output logic                  O_MemError
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_tmo_cnt, w_tmo_cnt_next;

  // Opcode decode
  logic w_is_ldb, w_is_ldw, w_is_stb, w_is_stw;
  logic w_is_load, w_is_store, w_is_mem, w_is_word;
  logic w_misaligned;

  // One-hot-ish control events for the datapath, produced by the FSM
  logic w_launch, w_complete, w_timeout, w_align_err, w_pass;

  // Registered outputs
  logic                  r_dmem_req, r_dmem_we;
  logic [ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic [1:0]            r_dmem_byte_en;
  logic                  r_lock, r_mem_valid;
  logic [15:0]           r_pc;
  logic [31:0]           r_ir;
  logic [3:0]            r_dest_idx;
  logic [DATA_WIDTH-1:0] r_dest_value;
  logic                  r_reg_wen, r_cc_wen;
  logic [2:0]            r_cc_value;
  logic                  r_mem_error;

  // Instruction fields captured at issue; EX moves on while we wait
  logic                  r_pend_load, r_pend_byte, r_pend_lane;
  logic [15:0]           r_pend_pc;
  logic [31:0]           r_pend_ir;
  logic [3:0]            r_pend_dest_idx;
  logic [DATA_WIDTH-1:0] r_pend_dest_value;
  logic [2:0]            r_pend_cc_value;

  // Load result formatting
  logic [7:0]            w_load_byte;
  logic [DATA_WIDTH-1:0] w_load_value;
  logic [2:0]            w_load_cc;

  assign w_is_ldb   = (I_Opcode == OP_LDB);
  assign w_is_ldw   = (I_Opcode == OP_LDW);
  assign w_is_stb   = (I_Opcode == OP_STB);
  assign w_is_stw   = (I_Opcode == OP_STW);
  assign w_is_load  = w_is_ldb | w_is_ldw;
  assign w_is_store = w_is_stb | w_is_stw;
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_is_word  = w_is_ldw | w_is_stw;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = w_is_word & I_MARValue[0];
`else
  assign w_misaligned = 1'b0;
`endif

  // Byte loads pick the lane from the original address bit 0 and sign-extend.
  assign w_load_byte  = r_pend_lane ? I_DMemRData[15:8] : I_DMemRData[7:0];
  assign w_load_value = r_pend_byte ? {{(DATA_WIDTH-8){w_load_byte[7]}}, w_load_byte}
                                    : I_DMemRData;
  assign w_load_cc    = w_load_value[DATA_WIDTH-1]     ? 3'b100 :
                        (w_load_value == '0)           ? 3'b010 : 3'b001;

  // State register and timeout counter.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tmo_cnt <= w_tmo_cnt_next;
    end
  end

  // Next-state logic. In ACCESS every input except the ack is ignored;
  // an ack on the same edge as the timeout wins because it is tested first.
  always_comb begin
    w_state_next   = r_state;
    w_tmo_cnt_next = r_tmo_cnt;
    w_launch       = 1'b0;
    w_complete     = 1'b0;
    w_timeout      = 1'b0;
    w_align_err    = 1'b0;
    w_pass         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (I_LOCK && I_EX_Valid && w_is_mem) begin
          if (w_misaligned) begin
            w_align_err = 1'b1;
          end else begin
            w_launch       = 1'b1;
            w_state_next   = ST_ACCESS;
            w_tmo_cnt_next = '0;
          end
        end else if (I_LOCK) begin
          w_pass = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (I_DMemAck) begin
          w_complete     = 1'b1;
          w_state_next   = ST_IDLE;
          w_tmo_cnt_next = '0;
        end else if (r_tmo_cnt == TO_LAST) begin
          w_timeout      = 1'b1;
          w_state_next   = ST_IDLE;
          w_tmo_cnt_next = '0;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_tmo_cnt_next = '0;
      end
    endcase
  end

  // Datapath: WB outputs default to a bubble each edge and are only
  // asserted by a pass-through or a completed access. With I_LOCK low a
  // completing access still finishes the handshake but retires as a bubble.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_dmem_req        <= 1'b0;
      r_dmem_we         <= 1'b0;
      r_dmem_addr       <= '0;
      r_dmem_wdata      <= '0;
      r_dmem_byte_en    <= 2'b00;
      r_lock            <= 1'b0;
      r_mem_valid       <= 1'b0;
      r_pc              <= '0;
      r_ir              <= '0;
      r_dest_idx        <= '0;
      r_dest_value      <= '0;
      r_reg_wen         <= 1'b0;
      r_cc_wen          <= 1'b0;
      r_cc_value        <= 3'b000;
      r_mem_error       <= 1'b0;
      r_pend_load       <= 1'b0;
      r_pend_byte       <= 1'b0;
      r_pend_lane       <= 1'b0;
      r_pend_pc         <= '0;
      r_pend_ir         <= '0;
      r_pend_dest_idx   <= '0;
      r_pend_dest_value <= '0;
      r_pend_cc_value   <= 3'b000;
    end else begin
      r_lock      <= I_LOCK;
      r_mem_error <= w_timeout | w_align_err;
      r_mem_valid <= 1'b0;
      r_reg_wen   <= 1'b0;
      r_cc_wen    <= 1'b0;

      if (w_pass) begin
        r_mem_valid  <= I_EX_Valid;
        r_reg_wen    <= I_RegWEn & I_EX_Valid;
        r_cc_wen     <= I_CCWEn & I_EX_Valid;
        r_pc         <= I_PC;
        r_ir         <= I_IR;
        r_dest_idx   <= I_DestRegIdx;
        r_dest_value <= I_DestValue;
        r_cc_value   <= I_CCValue;
      end

      if (w_align_err) begin
        r_pc         <= I_PC;
        r_ir         <= I_IR;
        r_dest_idx   <= I_DestRegIdx;
        r_dest_value <= I_DestValue;
        r_cc_value   <= I_CCValue;
      end

      // Memory always sees a word address; lane selection rides on ByteEn.
      if (w_launch) begin
        r_dmem_req        <= 1'b1;
        r_dmem_we         <= w_is_store;
        r_dmem_addr       <= {I_MARValue[ADDR_WIDTH-1:1], 1'b0};
        if (w_is_stb) begin
          r_dmem_wdata <= DATA_WIDTH'({I_MDRValue[7:0], I_MDRValue[7:0]});
        end else if (w_is_stw) begin
          r_dmem_wdata <= I_MDRValue;
        end else begin
          r_dmem_wdata <= '0;
        end
        if (w_is_word) begin
          r_dmem_byte_en <= 2'b11;
        end else begin
          r_dmem_byte_en <= I_MARValue[0] ? 2'b10 : 2'b01;
        end
        r_pend_load       <= w_is_load;
        r_pend_byte       <= w_is_ldb;
        r_pend_lane       <= I_MARValue[0];
        r_pend_pc         <= I_PC;
        r_pend_ir         <= I_IR;
        r_pend_dest_idx   <= I_DestRegIdx;
        r_pend_dest_value <= I_DestValue;
        r_pend_cc_value   <= I_CCValue;
      end

      if (w_complete) begin
        r_dmem_req     <= 1'b0;
        r_dmem_we      <= 1'b0;
        r_dmem_addr    <= '0;
        r_dmem_wdata   <= '0;
        r_dmem_byte_en <= 2'b00;
        r_pc           <= r_pend_pc;
        r_ir           <= r_pend_ir;
        r_dest_idx     <= r_pend_dest_idx;
        r_dest_value   <= r_pend_load ? w_load_value : r_pend_dest_value;
        r_cc_value     <= r_pend_load ? w_load_cc : r_pend_cc_value;
        if (I_LOCK) begin
          r_mem_valid <= 1'b1;
          r_reg_wen   <= r_pend_load;
          r_cc_wen    <= r_pend_load;
        end
      end

      if (w_timeout) begin
        r_dmem_req     <= 1'b0;
        r_dmem_we      <= 1'b0;
        r_dmem_addr    <= '0;
        r_dmem_wdata   <= '0;
        r_dmem_byte_en <= 2'b00;
        r_pc           <= r_pend_pc;
        r_ir           <= r_pend_ir;
        r_dest_idx     <= r_pend_dest_idx;
      end
    end
  end

  assign O_DMemReq        = r_dmem_req;
  assign O_DMemWE         = r_dmem_we;
  assign O_DMemAddr       = r_dmem_addr;
  assign O_DMemWData      = r_dmem_wdata;
  assign O_DMemByteEn     = r_dmem_byte_en;
  assign O_LOCK           = r_lock;
  assign O_MEM_Valid      = r_mem_valid;
  assign O_PC             = r_pc;
  assign O_IR             = r_ir;
  assign O_DestRegIdx     = r_dest_idx;
  assign O_DestValue      = r_dest_value;
  assign O_RegWEn         = r_reg_wen;
  assign O_CCWEn          = r_cc_wen;
  assign O_CCValue        = r_cc_value;
  assign O_MemError       = r_mem_error;
  assign O_MEMStallSignal = (r_state == ST_ACCESS);

endmodule
